// File: rtl/sra_share_arbiter_pkg.sv
// Shared constants for the SRA share arbiter: FSM state encodings, default widths
// and the helper that sizes the grant index.
package sra_share_arbiter_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int SHAMT_W_DEF = 5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Width of an index able to name n requesters; never less than one bit.
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/sra_share_arbiter_sra.sv
// Combinational 32-bit arithmetic right shifter shared by all requesters.
module sra_share_arbiter_sra #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic [DATA_W-1:0]  a,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [DATA_W-1:0]  y
);

  assign y = $unsigned($signed(a) >>> shamt);

endmodule

// File: rtl/sra_share_arbiter.sv
// Round-robin arbiter sharing one SRA between N_REQ valid/ready requesters,
// with registered operands, a registered result and one operation in flight.
module sra_share_arbiter
  import sra_share_arbiter_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*DATA_W-1:0]    req_a,
  input  logic [N_REQ*SHAMT_W-1:0]   req_shamt,
  output logic [N_REQ-1:0]           rsp_valid,
  output logic [DATA_W-1:0]          rsp_data,
  input  logic [N_REQ-1:0]           rsp_ready,
  output logic                       busy
);

  localparam int IDX_W = idx_width(N_REQ);

  typedef struct packed {
    logic             hit;
    logic [IDX_W-1:0] idx;
  } pick_t;

  logic [1:0]         state_q,  state_d;
  logic [IDX_W-1:0]   grant_q,  grant_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0]  a_q,      a_d;
  logic [SHAMT_W-1:0] shamt_q,  shamt_d;
  logic [DATA_W-1:0]  res_q,    res_d;
  logic [DATA_W-1:0]  sra_y;
  pick_t              pick;

  // First requester at or after ptr, wrapping; scanning downward lets the
  // smallest offset win.
  function automatic pick_t rr_pick(input logic [N_REQ-1:0] valid,
                                    input logic [IDX_W-1:0] ptr);
    pick_t p;
    int    k;
    p = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = (int'(ptr) + i) % N_REQ;
      if (valid[k]) begin
        p.hit = 1'b1;
        p.idx = IDX_W'(k);
      end
    end
    return p;
  endfunction

  assign pick = rr_pick(req_valid, rr_ptr_q);
  assign busy = (state_q != ST_IDLE);

  sra_share_arbiter_sra #(
    .DATA_W  (DATA_W),
    .SHAMT_W (SHAMT_W)
  ) u_sra (
    .a     (a_q),
    .shamt (shamt_q),
    .y     (sra_y)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case so no path infers a latch.
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    a_d       = a_q;
    shamt_d   = shamt_q;
    res_d     = res_q;
    req_ready = '0;
    rsp_valid = '0;
    rsp_data  = '0;

    case (state_q)
      ST_IDLE: begin
        if (pick.hit) begin
          // Handshakes are suppressed while reset is held, since reset wins at the edge.
          req_ready[pick.idx] = reset_n;
          a_d      = req_a[int'(pick.idx)*DATA_W +: DATA_W];
          shamt_d  = req_shamt[int'(pick.idx)*SHAMT_W +: SHAMT_W];
          grant_d  = pick.idx;
          rr_ptr_d = (int'(pick.idx) == N_REQ - 1) ? '0 : pick.idx + 1'b1;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        res_d   = sra_y;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (reset_n) begin
          rsp_valid[grant_q] = 1'b1;
          rsp_data           = res_q;
        end
        if (rsp_ready[grant_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      a_q      <= '0;
      shamt_q  <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      a_q      <= a_d;
      shamt_q  <= shamt_d;
      res_q    <= res_d;
    end
  end

endmodule
